wallace_issue_ctrl: RTL

- Issue/retire controller for the pipelined 32x32 Wallace-tree multiplier with its CLA final adder.
- Accepts tagged multiply requests through a valid/ready handshake and tracks each operation through the datapath pipeline ranks with a valid/tag shift chain.
- Captures each product into a small result FIFO and presents it downstream with backpressure.
- Credit-based admission means an accepted operation always has a FIFO slot, so the datapath never stalls and needs no enables.

---
 rtl/wallace_ctrl_pkg.sv | 20 ++
 rtl/wallace_res_fifo.sv | 62 ++++++
 rtl/wallace_issue_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/wallace_ctrl_pkg.sv
// Shared types and sizing helpers for the Wallace multiplier issue/retire controller.
// Used by wallace_issue_ctrl and wallace_res_fifo.
package wallace_ctrl_pkg;

  localparam int DEF_STAGES = 4;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_TAG_W  = 4;
  localparam int DEF_RES_W  = 64;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_RES_W-1:0] result;
  } res_entry_t;

  // Credits span 0..DEPTH inclusive, hence the +1.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wallace_res_fifo.sv
// First-word-fall-through result FIFO with synchronous clear (flush) and async active-low reset.
// The head output holds its last shown value once the FIFO drains.
module wallace_res_fifo
  import wallace_ctrl_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  parameter type T     = res_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_wr,
  input  T     i_data,
  input  logic i_pop,
  output logic o_valid,
  output T     o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = credit_w(DEPTH);

  T               r_mem [DEPTH];
  T               r_hold;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_wr;
  logic           w_do_pop;

  assign o_valid  = (r_count != '0);
  assign w_do_wr  = i_wr & ~i_clr;
  assign w_do_pop = i_pop & o_valid & ~i_clr;
  assign o_data   = o_valid ? r_mem[r_rd_ptr] : r_hold;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_wr && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_wr && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_hold <= '0;
    else if (o_valid) r_hold <= r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/wallace_issue_ctrl.sv
// Issue/retire controller for the pipelined Wallace multiplier: valid/tag shift chain, credits, dp_rst.
// Optional performance counters are built when WALLACE_CTRL_PERF_EN is defined.
module wallace_issue_ctrl
  import wallace_ctrl_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int RES_W  = DEF_RES_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  output logic             dp_rst,
  input  logic [RES_W-1:0] dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef WALLACE_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_retired,
  output logic [31:0]      perf_stall
`endif
);

  localparam int CW = credit_w(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [RES_W-1:0] result;
  } entry_t;

  logic [STAGES-1:0] r_v;
  logic [TAG_W-1:0]  r_tg [STAGES];
  logic [CW-1:0]     r_credits;
  logic              r_dp_rst;
  logic              w_issue;
  logic              w_pop;
  logic              w_fifo_wr;
  entry_t            w_wr_entry;
  entry_t            w_head;

  assign in_ready   = (r_credits != '0) & ~flush;
  assign w_issue    = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready & ~flush;
  assign w_fifo_wr  = r_v[STAGES-1] & ~flush;
  assign w_wr_entry = '{tag: r_tg[STAGES-1], result: dp_result};
  assign busy       = (r_credits != CW'(DEPTH));
  assign dp_rst     = r_dp_rst;
  assign out_tag    = w_head.tag;
  assign out_result = w_head.result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v <= '0;
      for (int i = 0; i < STAGES; i++) r_tg[i] <= '0;
    end else begin
      r_v     <= flush ? '0 : {r_v[STAGES-2:0], w_issue};
      r_tg[0] <= in_tag;
      for (int i = 1; i < STAGES; i++) r_tg[i] <= r_tg[i-1];
    end
  end

  // Credits = free FIFO slots not already promised to an in-flight op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credits <= CW'(DEPTH);
    end else if (flush) begin
      r_credits <= CW'(DEPTH);
    end else if (w_issue && !w_pop) begin
      r_credits <= r_credits - CW'(1);
    end else if (!w_issue && w_pop) begin
      r_credits <= r_credits + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_dp_rst <= 1'b0;
    else      r_dp_rst <= ~flush;
  end

  wallace_res_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_wr    (w_fifo_wr),
    .i_data  (w_wr_entry),
    .i_pop   (out_ready),
    .o_valid (out_valid),
    .o_data  (w_head)
  );

`ifdef WALLACE_CTRL_PERF_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued  <= '0;
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (w_issue)               perf_issued  <= perf_issued + 32'd1;
      if (w_pop)                 perf_retired <= perf_retired + 32'd1;
      if (in_valid && !in_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
